// File: rtl/decryption_cfg_arbiter_if.sv
// Requester and register-bank signal bundle for decryption_cfg_arbiter.
// master = the arbiter; slave = the requesters plus the register bank.
interface decryption_cfg_arbiter_if #(
  parameter int addr_width = 8,
  parameter int reg_width  = 16
);
  logic [1:0]              req_valid;
  logic [1:0]              req_we;
  logic [2*addr_width-1:0] req_addr;
  logic [2*reg_width-1:0]  req_wdata;
  logic [1:0]              req_ready;
  logic [1:0]              resp_valid;
  logic [reg_width-1:0]    resp_rdata;
  logic                    resp_error;
  logic [addr_width-1:0]   rf_addr;
  logic                    rf_read;
  logic                    rf_write;
  logic [reg_width-1:0]    rf_wdata;
  logic [reg_width-1:0]    rf_rdata;
  logic                    rf_done;
  logic                    rf_error;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rf_rdata, rf_done, rf_error,
    output req_ready, resp_valid, resp_rdata, resp_error,
           rf_addr, rf_read, rf_write, rf_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rf_rdata, rf_done, rf_error,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           rf_addr, rf_read, rf_write, rf_wdata
  );
endinterface

// File: rtl/decryption_cfg_arbiter.sv
// Round-robin arbiter sharing one register-bank access at a time between the
// host port (0) and the key-loader port (1), with a bounded wait for rf_done.
//
// state | meaning
// IDLE  | arbitrate; latch winner's request
// ISSUE | one-cycle read/write strobe and req_ready to the winner
// WAIT  | wait for rf_done, or force an error after timeout cycles
// RESP  | one-cycle resp_valid to the winner
module decryption_cfg_arbiter #(
  parameter int addr_width = 8,
  parameter int reg_width  = 16,
  parameter int timeout    = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  decryption_cfg_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int cnt_w = $clog2(timeout + 1);
  localparam logic [cnt_w-1:0] tmo_c = cnt_w'(timeout);

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic [cnt_w-1:0]      cnt_q, cnt_d;
  logic [cnt_w-1:0]      cnt_inc;
  logic [1:0]            req_ready_q, req_ready_d;
  logic [1:0]            resp_valid_q, resp_valid_d;
  logic [reg_width-1:0]  resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;
  logic [addr_width-1:0] rf_addr_q, rf_addr_d;
  logic [reg_width-1:0]  rf_wdata_q, rf_wdata_d;
  logic                  rf_read_q, rf_read_d;
  logic                  rf_write_q, rf_write_d;
  logic                  winner;
  logic                  win_we;
  logic [1:0]            grant_oh;

  // On a tie the port that was not served last wins.
  always_comb begin
    winner = 1'b0;
    if (bus.req_valid == 2'b11) begin
      winner = ~last_grant_q;
    end else if (bus.req_valid[1]) begin
      winner = 1'b1;
    end
  end

  assign win_we   = winner ? bus.req_we[1] : bus.req_we[0];
  assign grant_oh = grant_q ? 2'b10 : 2'b01;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    req_ready_d  = 2'b00;
    resp_valid_d = 2'b00;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    rf_addr_d    = rf_addr_q;
    rf_wdata_d   = rf_wdata_q;
    rf_read_d    = 1'b0;
    rf_write_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          grant_d      = winner;
          last_grant_d = winner;
          we_d         = win_we;
          rf_addr_d    = winner ? bus.req_addr[2*addr_width-1:addr_width]
                                : bus.req_addr[addr_width-1:0];
          rf_wdata_d   = winner ? bus.req_wdata[2*reg_width-1:reg_width]
                                : bus.req_wdata[reg_width-1:0];
          rf_write_d   = win_we;
          rf_read_d    = ~win_we;
          req_ready_d  = winner ? 2'b10 : 2'b01;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.rf_done) begin
          resp_rdata_d = bus.rf_rdata;
          resp_error_d = bus.rf_error;
          resp_valid_d = grant_oh;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          // A bank that never answers still yields a response to the requester.
          if (cnt_inc == tmo_c) begin
            resp_rdata_d = '0;
            resp_error_d = 1'b1;
            resp_valid_d = grant_oh;
            state_d      = ST_RESP;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= 2'b00;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      rf_addr_q    <= '0;
      rf_wdata_q   <= '0;
      rf_read_q    <= 1'b0;
      rf_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      rf_addr_q    <= rf_addr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_read_q    <= rf_read_d;
      rf_write_q   <= rf_write_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_read    = rf_read_q;
  assign bus.rf_write   = rf_write_q;

endmodule

// File: tb/tb_decryption_cfg_arbiter.sv
// Directed bench for decryption_cfg_arbiter with a register-bank stub and a
// response scoreboard filled as requests are driven.
module tb_decryption_cfg_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hang = 1'b0;
  logic mon_en = 1'b0;
  logic gap_mode = 1'b0;
  logic gap_armed = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int ready_cnt = 0;
  int resp_cnt = 0;
  int last_ready_cyc = 0;
  int last_resp_cyc = 0;
  int last_strobe_cyc = 0;

  typedef struct packed {
    logic [1:0]  port;
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [15:0] bank [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0002};

  always #5 clk = ~clk;

  decryption_cfg_arbiter_if #(.addr_width(8), .reg_width(16)) bus ();

  decryption_cfg_arbiter #(.addr_width(8), .reg_width(16), .timeout(4)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register bank stub: registered done/rdata/error one cycle after a strobe.
  always @(posedge clk) begin
    int idx;
    bus.rf_done  <= 1'b0;
    bus.rf_error <= 1'b0;
    bus.rf_rdata <= 16'h0000;
    if ((bus.rf_read === 1'b1 || bus.rf_write === 1'b1) && !hang) begin
      bus.rf_done <= 1'b1;
      case (bus.rf_addr)
        8'h00:   idx = 0;
        8'h10:   idx = 1;
        8'h12:   idx = 2;
        8'h14:   idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        bus.rf_error <= 1'b1;
      end else if (bus.rf_write === 1'b1) begin
        bank[idx] <= bus.rf_wdata;
      end else begin
        bus.rf_rdata <= bank[idx];
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_en) begin
      chk("strobe_excl", 64'(bus.rf_read & bus.rf_write), 64'd0);
      if (bus.rf_read || bus.rf_write) begin
        strobe_cnt++;
        if (gap_mode && gap_armed) chk("strobe_gap", 64'(cyc - last_strobe_cyc), 64'd4);
        if (gap_mode) gap_armed = 1'b1;
        last_strobe_cyc = cyc;
      end
      if (|bus.req_ready) begin
        ready_cnt++;
        last_ready_cyc = cyc;
      end
      if (|bus.resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_port", 64'(bus.resp_valid), 64'(e.port));
          chk("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
          chk("resp_error", 64'(bus.resp_error), 64'(e.err));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] port, input logic [15:0] rdata, input logic err);
    exp_t e;
    e.port = port;
    e.rdata = rdata;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic req(input int port, input logic we, input logic [7:0] addr, input logic [15:0] wdata);
    bus.req_we[port] = we;
    bus.req_addr[port*8 +: 8] = addr;
    bus.req_wdata[port*16 +: 16] = wdata;
    bus.req_valid[port] = 1'b1;
  endtask

  task automatic wait_ready(input int port);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_ready[port]) seen = 1'b1;
    end
    chk($sformatf("ready_wait_p%0d", port), 64'(seen), 64'd1);
    step();
    bus.req_valid[port] = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 100 && resp_cnt < target; i++) @(negedge clk);
    chk("resp_wait", 64'(resp_cnt >= target), 64'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0;
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (2) step();
    chk("reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error,
                          bus.rf_addr, bus.rf_read, bus.rf_write, bus.rf_wdata}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Simultaneous requests after reset: order 0,1,0,1.
    push_exp(2'b01, 16'hFFFF, 1'b0);
    push_exp(2'b10, 16'h0002, 1'b0);
    req(0, 1'b0, 8'h12, 16'h0000);
    req(1, 1'b0, 8'h14, 16'h0000);
    wait_ready(0);
    wait_ready(1);
    wait_resp(2);
    push_exp(2'b01, 16'hFFFF, 1'b0);
    push_exp(2'b10, 16'h0002, 1'b0);
    req(0, 1'b0, 8'h12, 16'h0000);
    req(1, 1'b0, 8'h14, 16'h0000);
    wait_ready(0);
    wait_ready(1);
    wait_resp(4);

    // Port 0 write 0x10 with cycle-accurate checks, then read back.
    push_exp(2'b01, 16'h0000, 1'b0);
    req(0, 1'b1, 8'h10, 16'h0003);
    step();
    chk("issue_write", 64'(bus.rf_write), 64'd1);
    chk("issue_read", 64'(bus.rf_read), 64'd0);
    chk("issue_addr", 64'(bus.rf_addr), 64'h10);
    chk("issue_wdata", 64'(bus.rf_wdata), 64'h3);
    chk("issue_ready", 64'(bus.req_ready), 64'b01);
    step();
    bus.req_valid[0] = 1'b0;
    chk("wait_write", 64'(bus.rf_write), 64'd0);
    chk("wait_addr_held", 64'(bus.rf_addr), 64'h10);
    chk("wait_ready_low", 64'(bus.req_ready), 64'd0);
    step();
    chk("resp_valid_n3", 64'(bus.resp_valid), 64'b01);
    step();
    chk("idle_resp_low", 64'(bus.resp_valid), 64'd0);
    push_exp(2'b01, 16'h0003, 1'b0);
    req(0, 1'b0, 8'h10, 16'h0000);
    wait_ready(0);
    wait_resp(6);
    chk("nominal_latency", 64'(last_resp_cyc - last_ready_cyc), 64'd2);

    // Invalid address from port 1.
    push_exp(2'b10, 16'h0000, 1'b1);
    req(1, 1'b0, 8'h05, 16'h0000);
    wait_ready(1);
    wait_resp(7);

    // Bank never answers: forced error after 4 WAIT cycles.
    hang = 1'b1;
    s0 = strobe_cnt;
    push_exp(2'b01, 16'h0000, 1'b1);
    req(0, 1'b0, 8'h00, 16'h0000);
    wait_ready(0);
    wait_resp(8);
    chk("timeout_strobes", 64'(strobe_cnt - s0), 64'd1);
    chk("timeout_latency", 64'(last_resp_cyc - last_ready_cyc), 64'd5);

    // Reset while in WAIT drops the transaction and restores port-0 priority.
    req(0, 1'b0, 8'h10, 16'h0000);
    wait_ready(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error,
                             bus.rf_addr, bus.rf_read, bus.rf_write, bus.rf_wdata}, 64'd0);
    repeat (8) step();
    chk("midreset_no_resp", 64'(resp_cnt), 64'd8);
    hang = 1'b0;
    push_exp(2'b01, 16'h0003, 1'b0);
    push_exp(2'b10, 16'hFFFF, 1'b0);
    req(0, 1'b0, 8'h10, 16'h0000);
    req(1, 1'b0, 8'h12, 16'h0000);
    wait_ready(0);
    wait_ready(1);
    wait_resp(10);

    // Port 1 streaming reads: one access every 4 cycles.
    s0 = strobe_cnt;
    r0 = ready_cnt;
    gap_armed = 1'b0;
    gap_mode = 1'b1;
    repeat (4) push_exp(2'b10, 16'h0002, 1'b0);
    req(1, 1'b0, 8'h14, 16'h0000);
    for (int i = 0; i < 100 && resp_cnt < 14; i++) @(negedge clk);
    bus.req_valid[1] = 1'b0;
    chk("stream_resp_count", 64'(resp_cnt), 64'd14);
    repeat (6) step();
    gap_mode = 1'b0;
    chk("stream_strobes", 64'(strobe_cnt - s0), 64'd4);
    chk("stream_readies", 64'(ready_cnt - r0), 64'd4);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decryption_cfg_arbiter.md
Name: decryption_cfg_arbiter

Overview:
Sequences and shares register-bank access between two requesters: port 0 (host/config interface) and port 1 (key-loader/test sequencer). The block arbitrates round-robin and issues one single-cycle read or write on the register-bank bus. It then collects that access's registered done/error/rdata and returns a one-cycle response to the granted port. It sits between the requesters and the register bank that holds the select and Caesar/Scytale/ZigZag key registers.

Parameters:
addr_width, 8, register address width
reg_width, 16, register data width
timeout, 4, max WAIT cycles for rf_done before a forced error response (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous reset, active-high (asserted = 1)
req_valid  input  2  per-port request valid; bit i = port i; held until that port's req_ready pulse
req_we  input  2  per-port 1 = write, 0 = read
req_addr  input  2*addr_width  per-port address; port i in bits [i*addr_width +: addr_width]
req_wdata  input  2*reg_width  per-port write data, same packing
req_ready  output  2  one-cycle accept pulse for the granted port
resp_valid  output  2  one-cycle response pulse for the granted port
resp_rdata  output  reg_width  read data, valid when any resp_valid bit is set
resp_error  output  1  error flag, valid with resp_valid
rf_addr  output  addr_width  register-bank address
rf_read  output  1  register-bank read strobe
rf_write  output  1  register-bank write strobe
rf_wdata  output  reg_width  register-bank write data
rf_rdata  input  reg_width  register-bank read data (registered, 1-cycle latency)
rf_done  input  1  register-bank done (registered, high the cycle after a strobe)
rf_error  input  1  register-bank invalid-address flag (registered)

Behaviour:
- Reset (rst_n=1 at posedge): state=IDLE. All outputs 0. last_grant=1, so port 0 wins the next tie. Wait counter=0. Any in-flight transaction is dropped with no resp_valid.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid bit is set, pick the winner.
  - Single requester: that port wins.
  - Both requesting: the port != last_grant wins.
  - Latch the winner's we/addr/wdata and update last_grant, then go to ISSUE. Otherwise stay.
- ISSUE (exactly 1 cycle):
  - rf_addr = latched addr; rf_wdata = latched wdata.
  - rf_write = we; rf_read = !we.
  - req_ready[grant] = 1.
  - Go to WAIT.
- WAIT:
  - rf_read = rf_write = 0; rf_addr and rf_wdata are held.
  - If rf_done=1: capture rf_rdata and rf_error, go to RESP.
  - Else increment the counter. When the counter reaches timeout, capture rdata=0 and error=1, go to RESP.
- RESP (1 cycle):
  - resp_valid[grant] = 1, with resp_rdata and resp_error from the capture.
  - Clear the counter, go to IDLE.
- Outputs are registered, driven from state/latched values.
- Strobes are mutually exclusive, never both high, and high only in ISSUE.
- Nominal timing:
  - Cycle N: IDLE samples valid.
  - N+1: ISSUE, strobe, req_ready.
  - N+2: WAIT sees rf_done.
  - N+3: RESP.
  - N+4: IDLE, earliest next arbitration.
  - Max throughput is one access per 4 cycles.
- rf_done or rf_error arriving in IDLE/ISSUE/RESP is ignored.
- A write response carries the register bank's rdata as returned (0 for writes).
- Only one outstanding transaction. A requester that keeps req_valid high after req_ready is treated as a new request at the next IDLE.
- req_valid deasserted before ready: the latched request still completes. The requester must not drop valid before ready.
- Error semantics come from the register bank. Valid addresses are 0x00, 0x10, 0x12 and 0x14; any other address returns error=1.

Test Plan:
1. Port 0 writes addr 0x10, wdata 0x0003 -> rf_write=1 at N+1 with rf_addr=0x10; resp_valid=2'b01 at N+3, error=0. Port 0 then reads 0x10 -> resp_rdata=0x0003.
2. After reset, both ports valid in the same cycle: port 0 reads 0x12, port 1 reads 0x14 -> port 0 served first (rdata 0xFFFF), then port 1 (rdata 0x0002). Repeat with both valid -> grant order alternates 0,1,0,1.
3. Port 1 reads invalid addr 0x05 -> resp_valid=2'b10, resp_error=1, resp_rdata=0.
4. Bank stub holds rf_done=0, timeout=4 -> RESP entered after 4 WAIT cycles; resp_error=1, resp_rdata=0; strobes seen only once.
5. rst_n=1 during WAIT -> no resp_valid, all outputs 0 next cycle, FSM IDLE. Both ports requesting afterwards -> port 0 granted first.
6. Port 1 valid continuously, port 0 idle -> rf_read pulses every 4 cycles, one req_ready and one resp_valid per access, never both strobes high.
